// File: rtl/rst_seq.sv
// rst_seq: ordered reset release (sync -> mem -> core) with optional software reset.
// Define RST_SEQ_SWRST_EN to build the software reset req/ack path.
module rst_seq #(
    parameter int unsigned STRETCH = 16,
    parameter int unsigned GAP     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sw_rst_req,
    output logic o_rst_sync,
    output logic o_rst_mem,
    output logic o_rst_core,
    output logic o_sw_rst_ack,
    output logic o_ready
);

    localparam int unsigned MAXC = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int unsigned CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] S_END = CW'(STRETCH - 1);
    localparam logic [CW-1:0] G_END = CW'(GAP - 1);

    typedef enum logic [2:0] {
        S_SYNC,
        S_STRETCH,
        S_GAP,
        S_RUN
`ifdef RST_SEQ_SWRST_EN
        , S_SWRST
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sync_q;
    logic          mem_q, mem_d;
    logic          core_q, core_d;
    logic          ready_q, ready_d;

`ifdef RST_SEQ_SWRST_EN
    logic ack_q, ack_d;
    logic req_q;
    logic sw_edge;

    assign sw_edge = i_sw_rst_req & ~req_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q <= 1'b0;
            req_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            req_q <= i_sw_rst_req;
        end
    end

    assign o_sw_rst_ack = ack_q;
`else
    logic unused_req;
    assign unused_req   = i_sw_rst_req;
    assign o_sw_rst_ack = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_SYNC;
            cnt_q   <= '0;
            sync_q  <= 2'b11;
            mem_q   <= 1'b1;
            core_q  <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= {sync_q[0], 1'b0};
            mem_q   <= mem_d;
            core_q  <= core_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        core_d  = core_q;
        ready_d = ready_q;
`ifdef RST_SEQ_SWRST_EN
        ack_d   = 1'b0;
`endif
        unique case (state_q)
            // Leave as the zero reaches the second flop so both change on one edge.
            S_SYNC: begin
                if (!sync_q[0]) begin
                    state_d = S_STRETCH;
                    cnt_d   = '0;
                end
            end
            S_STRETCH: begin
                if (cnt_q == S_END) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    mem_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == G_END) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    core_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
`ifdef RST_SEQ_SWRST_EN
                if (sw_edge) begin
                    state_d = S_SWRST;
                    mem_d   = 1'b1;
                    core_d  = 1'b1;
                    ready_d = 1'b0;
                    ack_d   = 1'b1;
                end
`endif
            end
`ifdef RST_SEQ_SWRST_EN
            S_SWRST: begin
                state_d = S_STRETCH;
                cnt_d   = '0;
            end
`endif
            default: begin
                state_d = S_SYNC;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_rst_sync = sync_q[1];
    assign o_rst_mem  = mem_q;
    assign o_rst_core = core_q;
    assign o_ready    = ready_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed scoreboard bench for rst_seq, two instances
// (STRETCH=16/GAP=4 and STRETCH=1/GAP=1) sharing clock, reset and request.
module tb_rst_seq;

    logic clk;
    logic rst;
    logic req;
    logic a_sync, a_mem, a_core, a_ack, a_ready;
    logic b_sync, b_mem, b_core, b_ack, b_ready;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] RSTV = 5'b11100;
    localparam logic [4:0] RUNV = 5'b00001;

    typedef struct {
        string      tag;
        logic [4:0] e1;
        logic [4:0] e2;
    } exp_t;

    exp_t sb[$];

    rst_seq #(.STRETCH(16), .GAP(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_sw_rst_req (req),
        .o_rst_sync   (a_sync),
        .o_rst_mem    (a_mem),
        .o_rst_core   (a_core),
        .o_sw_rst_ack (a_ack),
        .o_ready      (a_ready)
    );

    rst_seq #(.STRETCH(1), .GAP(1)) dut_small (
        .clk          (clk),
        .rst          (rst),
        .i_sw_rst_req (req),
        .o_rst_sync   (b_sync),
        .o_rst_mem    (b_mem),
        .o_rst_core   (b_core),
        .o_sw_rst_ack (b_ack),
        .o_ready      (b_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // k = edges since rst released, E1 counted as 1
    function automatic logic [4:0] pu(int k, int s, int g);
        logic sy, me, co;
        sy = (k < 2);
        me = (k < 2 + s);
        co = (k < 2 + s + g);
        return {sy, me, co, 1'b0, ~co};
    endfunction

    // m = edges since the request-sampling edge R, R counted as 0
    function automatic logic [4:0] sw(int m, int s, int g);
        logic me, co, ak;
        ak = (m == 0);
        me = (m < 1 + s);
        co = (m < 1 + s + g);
        return {1'b0, me, co, ak, ~co};
    endfunction

    task automatic check_pop();
        exp_t e;
        logic [4:0] o1, o2;
        e  = sb.pop_front();
        o1 = {a_sync, a_mem, a_core, a_ack, a_ready};
        o2 = {b_sync, b_mem, b_core, b_ack, b_ready};
        checks++;
        assert (o1 === e.e1) else begin
            errors++;
            $error("FAIL %s big: observed %b expected %b", e.tag, o1, e.e1);
        end
        checks++;
        assert (o2 === e.e2) else begin
            errors++;
            $error("FAIL %s small: observed %b expected %b", e.tag, o2, e.e2);
        end
    endtask

    task automatic cyc(string tag, logic [4:0] e1, logic [4:0] e2);
        sb.push_back('{tag, e1, e2});
        @(posedge clk);
        @(negedge clk);
        check_pop();
    endtask

    task automatic now(string tag, logic [4:0] e1, logic [4:0] e2);
        sb.push_back('{tag, e1, e2});
        #1;
        check_pop();
    endtask

    task automatic run_pu(string tag, int n, int on, int off);
        for (int k = 1; k <= n; k++) begin
            if (k == on) req = 1'b1;
            if (k == off) req = 1'b0;
            cyc(tag, pu(k, 16, 4), pu(k, 1, 1));
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 1'b0;

        repeat (5) cyc("hold", RSTV, RSTV);
        rst = 1'b0;
        run_pu("pwr", 24, -1, -1);

        #2 rst = 1'b1;
        now("async", RSTV, RSTV);
        @(negedge clk);
        repeat (3) cyc("async_hold", RSTV, RSTV);
        rst = 1'b0;
        run_pu("async_rel", 24, -1, -1);

`ifdef RST_SEQ_SWRST_EN
        req = 1'b1;
        cyc("sw_ack", sw(0, 16, 4), sw(0, 1, 1));
        req = 1'b0;
        for (int m = 1; m <= 24; m++)
            cyc("sw_seq", sw(m, 16, 4), sw(m, 1, 1));

        req = 1'b1;
        for (int m = 0; m < 40; m++)
            cyc("held", sw(m, 16, 4), sw(m, 1, 1));
        req = 1'b0;
        repeat (2) cyc("held_drop", RUNV, RUNV);
        req = 1'b1;
        cyc("reraise", sw(0, 16, 4), sw(0, 1, 1));
        req = 1'b0;
        for (int m = 1; m <= 24; m++)
            cyc("reraise_seq", sw(m, 16, 4), sw(m, 1, 1));
`else
        req = 1'b1;
        repeat (10) cyc("sw_off", RUNV, RUNV);
        req = 1'b0;
`endif

        #1 rst = 1'b1;
        now("short_on", RSTV, RSTV);
        #1 rst = 1'b0;
        now("short_off", RSTV, RSTV);
        run_pu("short_ign", 24, 5, 8);

        #2 rst = 1'b1;
        now("mid_a", RSTV, RSTV);
        @(negedge clk);
        rst = 1'b0;
        run_pu("mid_pre", 20, -1, -1);
        #2 rst = 1'b1;
        now("mid_gap", RSTV, RSTV);
        @(negedge clk);
        repeat (2) cyc("mid_hold", RSTV, RSTV);
        rst = 1'b0;
        run_pu("mid_rel", 24, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
